// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: width ratios, power-of-two tests
// and the configuration check every FIFO elaborates against.
package fifo_pkg;

  function automatic int f_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit f_is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Number of G-bit units in a w-bit word.
  function automatic int f_ratio(input int w, input int g);
    return w / g;
  endfunction

  function automatic bit f_wconv_ok(
    input int w,
    input int r,
    input int depth
  );
    int g;
    int mx;
    g  = f_min(w, r);
    mx = f_max(w, r);
    return (g > 0)
      && (w % g == 0)
      && (r % g == 0)
      && f_is_pow2(mx / g)
      && f_is_pow2(depth)
      && (depth >= 2 * (mx / g));
  endfunction

endpackage

// File: rtl/sync_fifo_wconv_ram.sv
// Unit-granular register array: WR-unit aligned write port,
// RR-unit aligned registered read port.
module sync_fifo_wconv_ram #(
  parameter int G       = 16,
  parameter int DEPTH_U = 16,
  parameter int WR      = 1,
  parameter int RR      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH_U)-1:0] waddr_i,
  input  logic [WR*G-1:0]            wdata_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH_U)-1:0] raddr_i,
  output logic [RR*G-1:0]            rdata_o
);

  localparam int AW = $clog2(DEPTH_U);

  logic [G-1:0]    mem_q [DEPTH_U];
  logic [RR*G-1:0] rdata_q;

  // Storage is never reset; pointers make stale data unreachable.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < WR; k++) begin
        mem_q[waddr_i + AW'(k)] <= wdata_i[k*G +: G];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      for (int k = 0; k < RR; k++) begin
        rdata_q[k*G +: G] <= mem_q[raddr_i + AW'(k)];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_wconv.sv
// Single-clock FIFO with independent write/read widths
// (upsize or downsize), level, threshold and sticky error flags.
module sync_fifo_wconv
  import fifo_pkg::*;
#(
  parameter int W_WIDTH  = 16,
  parameter int R_WIDTH  = 32,
  parameter int DEPTH_U  = 16,
  parameter int AF_LEVEL = DEPTH_U - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W_WIDTH-1:0]       wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [R_WIDTH-1:0]       rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic [$clog2(DEPTH_U):0] level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int G  = f_min(W_WIDTH, R_WIDTH);
  localparam int WR = f_ratio(W_WIDTH, G);
  localparam int RR = f_ratio(R_WIDTH, G);
  localparam int AW = $clog2(DEPTH_U);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] WR_P    = PW'(WR);
  localparam logic [PW-1:0] RR_P    = PW'(RR);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH_U);
  localparam logic [PW-1:0] AF_P    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_P    = PW'(AE_LEVEL);

  if (!f_wconv_ok(W_WIDTH, R_WIDTH, DEPTH_U)) begin : g_cfg_err
    $error("sync_fifo_wconv: illegal width/depth combination");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] free_units;
  logic          rd_valid_q;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_ok, rd_ok;

  // Pointers carry a wrap bit, so the difference is the fill level.
  assign level        = wr_ptr_q - rd_ptr_q;
  assign free_units   = DEPTH_P - level;
  assign full         = free_units < WR_P;
  assign empty        = level < RR_P;
  assign almost_full  = level >= AF_P;
  assign almost_empty = level <= AE_P;

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q | (wr_en & full);
    unf_d    = unf_q | (rd_en & empty);
    if (wr_ok) wr_ptr_d = wr_ptr_q + WR_P;
    if (rd_ok) rd_ptr_d = rd_ptr_q + RR_P;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_ok;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  sync_fifo_wconv_ram #(
    .G       (G),
    .DEPTH_U (DEPTH_U),
    .WR      (WR),
    .RR      (RR)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_ok & rst_n),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

endmodule

// File: doc/sync_fifo_wconv.md
# sync_fifo_wconv

Synchronous single-clock FIFO with independent write and read widths. Either side may be the wider one: the FIFO upsizes (narrow writes, wide reads) or downsizes (wide writes, narrow reads). It is the parametrised successor of the team's fixed multiple-write/single-read FIFO, and adds a fill-level output, almost-full/almost-empty flags and sticky overflow/underflow flags. It sits between datapath stages whose bus widths differ, for example 16-bit sample producers feeding 32- or 64-bit packers, or wide frames feeding narrow serial stages.

## Interface
- W_WIDTH, 16, write word width in bits.
- R_WIDTH, 32, read word width in bits.
- DEPTH_U, 16, capacity in units of G = min(W_WIDTH, R_WIDTH) bits; power of two; at least 2·max(WR, RR).
- AF_LEVEL, DEPTH_U-2, almost_full asserts when level ≥ AF_LEVEL (units).
- AE_LEVEL, 2, almost_empty asserts when level ≤ AE_LEVEL (units).
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write request.
- wr_data  in  W_WIDTH  write word.
- full  out  1  fewer than WR free units; a write is refused.
- rd_en  in  1  read request.
- rd_data  out  R_WIDTH  registered read word.
- rd_valid  out  1  rd_data was updated by the read accepted in the previous cycle.
- empty  out  1  fewer than RR stored units; a read is refused.
- level  out  $clog2(DEPTH_U)+1  stored units.
- almost_full, almost_empty  out  1  threshold flags.
- overflow, underflow  out  1  sticky error flags; cleared only by reset.

## Operation
- Derived constants: G = min(W,R); WR = W_WIDTH/G; RR = R_WIDTH/G. max(W,R)/G must be a power of two. Elaboration fails otherwise, and also if DEPTH_U is not a power of two.
- Storage is DEPTH_U entries of G bits. wr_ptr and rd_ptr are unit pointers with $clog2(DEPTH_U)+1 bits; the extra MSB is the wrap bit.
- wr_ptr always advances by WR and rd_ptr by RR, so both stay aligned and a wide access never straddles the wrap point.
- Write accepted = wr_en & !full:
  - Unit k of wr_data (bits [k·G +: G]) goes to mem[wr_ptr+k], k = 0..WR-1.
  - wr_ptr += WR.
- Read accepted = rd_en & !empty:
  - Bits rd_data[k·G +: G] take mem[rd_ptr+k], k = 0..RR-1.
  - rd_ptr += RR.
- Packing is little-endian: the earliest-written unit occupies the LSBs.
- level = wr_ptr − rd_ptr, modulo 2^(ADDR+1).
- full = (DEPTH_U − level) < WR. empty = level < RR. Both are combinational from the registered pointers.
- Write refused (wr_en & full): storage and pointers unchanged; overflow ← 1.
- Read refused (rd_en & empty): rd_data holds, rd_valid = 0; underflow ← 1.
- Simultaneous read and write: each is judged on the pre-edge flags, and both may be accepted in the same cycle. There is no bypass:
  - a write to a full FIFO is refused even if a read is accepted in the same cycle;
  - a read from an empty FIFO is refused even if a write is accepted in the same cycle.
- Upsizing with a partially filled word: empty stays high until RR units exist. Partial words are never emitted.

## Timing
- Write latency: data written at edge N is readable by a read request at edge N+1 at the earliest.
- Read latency: read accepted at edge N → rd_data and rd_valid = 1 after edge N. rd_valid is a single-cycle pulse per accepted read.
- Flags, level and thresholds reflect the pointers after each edge, with no extra lag.
- Reset (rst_n = 0 at an edge), applied at any time including mid-transfer:
  - wr_ptr = rd_ptr = 0; rd_data = 0; rd_valid = 0; level = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = underflow = 0.
  - Memory contents are not cleared; they are unreachable after reset.
- Reset overrides wr_en and rd_en in the same cycle.

## Structure
- Shared package fifo_pkg holds:
  - functions f_min, f_max, f_is_pow2;
  - the ratio derivation used by WR, RR and G;
  - the elaboration-check macro/function used by every FIFO in the codebase.
- One sub-module, sync_fifo_wconv_ram: a G-bit × DEPTH_U register array with
  - a WR-unit aligned write port, and
  - an RR-unit aligned read port, registered.
- Pointer, flag and level logic stays in the top module.

## Test plan
- Upsize (W=16, R=32, DEPTH_U=16): write 0x1111 then 0x2222 → empty falls after the second write; read → rd_data = 0x22221111, rd_valid pulses once.
- Downsize (W=32, R=8, DEPTH_U=16): write 0xDDCCBBAA → 4 reads return 0xAA, 0xBB, 0xCC, 0xDD; empty = 1 after the 4th read.
- Full/overflow (W=16, R=32): 16 writes → full = 1, level = 16; 17th write refused, contents unchanged, overflow = 1 and stays set. Then 8 reads return the data in write order, crossing the pointer wrap correctly.
- Underflow and partial word (W=16, R=32): one write then rd_en → refused, underflow = 1, rd_valid = 0, level = 1.
- Simultaneous operation at level 8 (W=R=16 instance): wr_en and rd_en held together for 20 cycles → level stays 8 and data order is preserved. Then at full with both asserted → read accepted, write refused, overflow = 1.
- Mid-operation reset at level 10, with wr_en = 1 during reset → all outputs take their reset values and level = 0. The first write after release appears as the first read.
